// File: rtl/spram_ctrl_pkg.sv
// Shared types for the SPRAM data-memory initiator: size/state encodings, widths,
// and the latched load-formatting context.
package spram_ctrl_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned WADDR_W = 14;
  localparam int unsigned MASK_W  = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCESS   = 3'd1,
    ST_RDATA    = 3'd2,
    ST_SLEEPING = 3'd3,
    ST_WAKE     = 3'd4
  } state_e;

  // What the read path needs to remember between accept and the data cycle
  typedef struct packed {
    size_e      size;
    logic [1:0] lo;
    logic       sgn;
  } ld_ctx_t;

  function automatic logic is_misaligned(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/spram_lane_align.sv
// Byte-lane steering between the 32-bit SPRAM word and processor data:
// store replicate + nibble mask, load extract + sign/zero extend.
module spram_lane_align
  import spram_ctrl_pkg::*;
(
  input  size_e               st_size,
  input  logic [1:0]          st_lo,
  input  logic [DATA_W-1:0]   st_wdata,
  output logic [DATA_W-1:0]   st_din_c,
  output logic [MASK_W-1:0]   st_mask_c,
  input  ld_ctx_t             ld_ctx,
  input  logic [DATA_W-1:0]   ld_dout,
  output logic [DATA_W-1:0]   ld_data_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store: each enabled byte lane owns two adjacent nibble-mask bits
  always_comb begin
    st_din_c  = st_wdata;
    st_mask_c = '0;
    case (st_size)
      SZ_BYTE: begin
        st_din_c  = {4{st_wdata[7:0]}};
        st_mask_c = MASK_W'(2'b11) << {st_lo, 1'b0};
      end
      SZ_HALF: begin
        st_din_c  = {2{st_wdata[15:0]}};
        st_mask_c = st_lo[1] ? MASK_W'(8'hF0) : MASK_W'(8'h0F);
      end
      SZ_WORD: st_mask_c = MASK_W'(8'hFF);
      default: st_mask_c = '0;
    endcase
  end

  assign ld_byte = ld_dout[{ld_ctx.lo, 3'b000} +: 8];
  assign ld_half = ld_dout[{ld_ctx.lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_c = '0;
    case (ld_ctx.size)
      SZ_BYTE: ld_data_c = {{24{ld_ctx.sgn & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data_c = {{16{ld_ctx.sgn & ld_half[15]}}, ld_half};
      SZ_WORD: ld_data_c = ld_dout;
      default: ld_data_c = '0;
    endcase
  end

endmodule

// File: rtl/spram_data_ctrl.sv
// Initiator for the cascaded 2x SB_SPRAM256KA data memory: request handshake,
// SPRAM control, response formatting. Optional idle sleep under SPRAM_SLEEP_EN.
module spram_data_ctrl
  import spram_ctrl_pkg::*;
`ifdef SPRAM_SLEEP_EN
#(
  parameter int unsigned IDLE_SLEEP_CYCLES = 1024,
  parameter int unsigned WAKE_CYCLES       = 3
)
`endif
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [WADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  output logic [MASK_W-1:0]   mem_mask_wren,
  output logic                mem_wren,
  output logic                mem_cs,
  output logic                mem_standby,
  output logic                mem_sleep,
  output logic                mem_poweroff,
  input  logic [DATA_W-1:0]   mem_dout
);

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_load_q, rsp_load_d;
  logic                acc_load_q, acc_load_d;
  logic                cs_q, cs_d;
  logic                wren_q, wren_d;
  logic [WADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  ld_ctx_t             ld_ctx_q, ld_ctx_d;

  size_e               req_size_c;
  logic                accept_c;
  logic                req_err_c;
  logic [DATA_W-1:0]   st_din_c;
  logic [MASK_W-1:0]   st_mask_c;
  logic [DATA_W-1:0]   ld_data_c;

`ifdef SPRAM_SLEEP_EN
  localparam int unsigned IDLE_CNT_W = $clog2(IDLE_SLEEP_CYCLES + 1);
  localparam int unsigned WAKE_CNT_W = $clog2(WAKE_CYCLES + 1);

  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic                  sleep_q, sleep_d;
`endif

  assign req_size_c = size_e'(req_size);
  assign accept_c   = (state_q == ST_IDLE) && ready_q && req_valid;
  assign req_err_c  = is_misaligned(req_size_c, req_addr[1:0]);

  spram_lane_align u_align (
    .st_size   (req_size_c),
    .st_lo     (req_addr[1:0]),
    .st_wdata  (req_wdata),
    .st_din_c  (st_din_c),
    .st_mask_c (st_mask_c),
    .ld_ctx    (ld_ctx_q),
    .ld_dout   (mem_dout),
    .ld_data_c (ld_data_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_load_d  = 1'b0;
    acc_load_d  = 1'b0;
    cs_d        = 1'b0;
    wren_d      = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    mask_d      = mask_q;
    ld_ctx_d    = ld_ctx_q;
`ifdef SPRAM_SLEEP_EN
    idle_cnt_d  = '0;
    wake_cnt_d  = '0;
    sleep_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_ACCESS;
          if (req_err_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            cs_d   = 1'b1;
            addr_d = req_addr[ADDR_W-1:2];
            if (req_we) begin
              wren_d      = 1'b1;
              din_d       = st_din_c;
              mask_d      = st_mask_c;
              rsp_valid_d = 1'b1;
            end else begin
              mask_d     = '0;
              acc_load_d = 1'b1;
              ld_ctx_d   = '{size: req_size_c, lo: req_addr[1:0], sgn: req_signed};
            end
          end
        end else begin
          ready_d = 1'b1;
`ifdef SPRAM_SLEEP_EN
          // A pending request always beats the sleep threshold
          if (!req_valid) begin
            if (idle_cnt_q == IDLE_CNT_W'(IDLE_SLEEP_CYCLES - 1)) begin
              state_d = ST_SLEEPING;
              ready_d = 1'b0;
              sleep_d = 1'b1;
            end else begin
              idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
            end
          end
`endif
        end
      end
      ST_ACCESS: begin
        if (acc_load_q) begin
          state_d     = ST_RDATA;
          rsp_valid_d = 1'b1;
          rsp_load_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_RDATA: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
`ifdef SPRAM_SLEEP_EN
      ST_SLEEPING: begin
        sleep_d = 1'b1;
        if (req_valid) begin
          state_d = ST_WAKE;
          sleep_d = 1'b0;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q == WAKE_CNT_W'(WAKE_CYCLES - 1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      acc_load_q  <= 1'b0;
      cs_q        <= 1'b0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      mask_q      <= '0;
      ld_ctx_q    <= '0;
`ifdef SPRAM_SLEEP_EN
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      sleep_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
      acc_load_q  <= acc_load_d;
      cs_q        <= cs_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      mask_q      <= mask_d;
      ld_ctx_q    <= ld_ctx_d;
`ifdef SPRAM_SLEEP_EN
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      sleep_q     <= sleep_d;
`endif
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  // SPRAM read data only exists in the response cycle, so loads are formatted directly from it
  assign rsp_rdata     = rsp_load_q ? ld_data_c : '0;
  assign mem_addr      = addr_q;
  assign mem_din       = din_q;
  assign mem_mask_wren = mask_q;
  assign mem_wren      = wren_q;
  assign mem_cs        = cs_q;
  assign mem_standby   = 1'b0;
  assign mem_poweroff  = 1'b1;
`ifdef SPRAM_SLEEP_EN
  assign mem_sleep     = sleep_q;
`else
  assign mem_sleep     = 1'b0;
`endif

endmodule

// File: tb/tb_spram_data_ctrl.sv
// Scoreboard bench for spram_data_ctrl: byte-addressed reference memory, SPRAM device
// model, directed spec cases plus random traffic. Sleep case built under SPRAM_SLEEP_EN.
module tb_spram_data_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic [7:0]  mem_mask_wren;
  logic        mem_wren, mem_cs, mem_standby, mem_sleep, mem_poweroff;
  logic [31:0] mem_dout = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { logic err; logic [31:0] rdata; int cyc; } rsp_exp_t;
  typedef struct { logic [13:0] addr; logic [31:0] din; logic [7:0] mask; } wr_exp_t;
  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];

  logic [7:0]  ref_mem [65536];
  logic [31:0] spram   [16384];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SPRAM_SLEEP_EN
  spram_data_ctrl #(.IDLE_SLEEP_CYCLES(8), .WAKE_CYCLES(3)) dut (
`else
  spram_data_ctrl dut (
`endif
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_mask_wren(mem_mask_wren),
    .mem_wren(mem_wren), .mem_cs(mem_cs), .mem_standby(mem_standby),
    .mem_sleep(mem_sleep), .mem_poweroff(mem_poweroff), .mem_dout(mem_dout)
  );

  // SPRAM device: nibble-masked write, registered read data
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_wren) begin
        for (int i = 0; i < 8; i++)
          if (mem_mask_wren[i]) spram[mem_addr][4*i +: 4] <= mem_din[4*i +: 4];
      end else begin
        mem_dout <= spram[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every response and every SPRAM write against the scoreboard
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (t=%0t)", $time);
      end else begin
        rsp_exp_t e;
        e = rsp_q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
    if (mem_cs && mem_wren) begin
      if (wr_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wr_unexpected: got SPRAM write addr %h expected none", mem_addr);
      end else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(w.addr));
        chk("wr_din", mem_din, w.din);
        chk("wr_mask", 32'(mem_mask_wren), 32'(w.mask));
      end
    end
  end

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
  endfunction

  // Waits for ready, hands over one request, records what the reference model expects
  task automatic issue(input logic we, input logic [15:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata);
    int budget, n;
    logic err;
    rsp_exp_t e;
    wr_exp_t w;
    logic [31:0] val;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wdata;
    budget = 0;
    while (!req_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 after %0d cycles expected 1", budget);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    n   = nbytes(size);
    err = (n == 0) || ((int'(addr) % n) != 0);
    e.err = err; e.rdata = '0; e.cyc = cyc;
    if (!err && we) begin
      w.addr = 14'(addr / 4);
      w.din  = '0;
      w.mask = '0;
      for (int l = 0; l < 4; l++) w.din[8*l +: 8] = wdata[8*(l % n) +: 8];
      for (int j = 0; j < n; j++) begin
        ref_mem[16'(int'(addr) + j)] = wdata[8*j +: 8];
        w.mask[2*((int'(addr) + j) % 4) +: 2] = 2'b11;
      end
      wr_q.push_back(w);
    end else if (!err) begin
      val = '0;
      for (int j = 0; j < n; j++) val = val | (32'(ref_mem[16'(int'(addr) + j)]) << (8*j));
      if (sgn && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
      e.rdata = val;
      e.cyc   = cyc + 1;
    end
    rsp_q.push_back(e);
    req_valid = 1'b0;
    req_wdata = $urandom;
    @(negedge clk);
    chk("acc_cs", 32'(mem_cs), 32'(!err));
    if (!err) begin
      chk("acc_wren", 32'(mem_wren), 32'(we));
      chk("acc_addr", 32'(mem_addr), 32'(addr) >> 2);
      if (!we) chk("acc_mask_load", 32'(mem_mask_wren), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_mem_bus"}, {4'(mem_cs), 4'(mem_wren), 8'(mem_mask_wren), 16'(mem_addr)}, 32'd0);
    chk({tag, "_mem_din"}, mem_din, 32'd0);
    chk({tag, "_mem_pwr"}, {29'd0, mem_poweroff, mem_sleep, mem_standby}, 32'b100);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 16384; i++) spram[i] = 32'h0;

    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_rst_high", 32'(req_ready), 32'd1);

    // Directed cases
    issue(1'b1, 16'h0010, 2'd2, 1'b0, 32'hDEADBEEF);
    issue(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);
    issue(1'b1, 16'h0013, 2'd0, 1'b0, 32'h000000A5);
    issue(1'b0, 16'h0013, 2'd0, 1'b1, 32'h0);
    issue(1'b0, 16'h0013, 2'd0, 1'b0, 32'h0);
    issue(1'b1, 16'h0010, 2'd2, 1'b0, 32'h80011234);
    issue(1'b0, 16'h0012, 2'd1, 1'b1, 32'h0);
    issue(1'b0, 16'h0012, 2'd1, 1'b0, 32'h0);
    issue(1'b0, 16'h0002, 2'd2, 1'b0, 32'h0);
    issue(1'b0, 16'h0001, 2'd1, 1'b1, 32'h0);
    issue(1'b1, 16'h0004, 2'd3, 1'b0, 32'h12345678);
    issue(1'b1, 16'h0006, 2'd2, 1'b0, 32'h12345678);

    // Reset asserted during a load's access cycle drops it
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_size = 2'd2; req_signed = 1'b0;
    for (int b = 0; b < 50 && !req_ready; b++) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    chk_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    issue(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);

`ifdef SPRAM_SLEEP_EN
    begin
      int wcnt;
      repeat (12) @(negedge clk);
      chk("sleep_entered", 32'(mem_sleep), 32'd1);
      chk("sleep_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_size = 2'd2;
      wcnt = 0;
      @(negedge clk);
      chk("wake_sleep_low", 32'(mem_sleep), 32'd0);
      while (!req_ready && wcnt < 20) begin
        wcnt++;
        @(negedge clk);
      end
      chk("wake_cycles", wcnt, 3);
      issue(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);
      issue(1'b0, 16'h0013, 2'd0, 1'b1, 32'h0);
    end
`else
    repeat (20) @(negedge clk);
    chk("no_sleep", 32'(mem_sleep), 32'd0);
`endif

    // Random traffic in two small windows so loads hit stored data
    for (int k = 0; k < 250; k++) begin
      logic [15:0] a;
      logic [1:0]  sz;
      a  = ($urandom_range(0, 1) != 0) ? 16'hFFC0 : 16'h0000;
      a  = a | 16'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8) begin
        if (sz == 2'd3) sz = 2'd2;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (6) @(negedge clk);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected $finish before 1ms");
    $fatal(1);
  end

endmodule
